// File: rtl/charge_session_ctrl.sv
// Multi-bay charging session controller: validates session requests against the mode
// table and runs one IDLE/CHARGE/DONE session machine per bay. Optional macro: CHARGE_BOOST_EN.
module charge_session_ctrl #(
    parameter int CHANNELS = 2,
    parameter int TIME_W   = 12,
    parameter int MODE_W   = 4,
    parameter int RATE_W   = 4
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        stop,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_sel,
    input  logic [MODE_W-1:0]                           mode,
    input  logic [TIME_W-1:0]                           duration,
    input  logic                                        tick,
    output logic                                        accept,
    output logic                                        reject,
    output logic [CHANNELS-1:0]                         busy,
    output logic [CHANNELS-1:0]                         done,
    output logic [CHANNELS-1:0]                         counter_enable,
    output logic [CHANNELS*RATE_W-1:0]                  counter_input,
    output logic [CHANNELS*TIME_W-1:0]                  remaining_time
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_DONE   = 2'd2
    } bay_state_t;

    // Returns {valid, rate}; unknown codes decode to an explicit invalid/zero pair.
    function automatic logic [RATE_W:0] decode_mode(input logic [MODE_W-1:0] m);
        logic [RATE_W:0] r;
        case (m)
            MODE_W'(4'b0010): r = {1'b1, RATE_W'(4'd1)};
            MODE_W'(4'b1010): r = {1'b1, RATE_W'(4'd5)};
`ifdef CHARGE_BOOST_EN
            MODE_W'(4'b1110): r = {1'b1, RATE_W'(4'd9)};
`endif
            default:          r = {1'b0, {RATE_W{1'b0}}};
        endcase
        return r;
    endfunction

    bay_state_t        state_r  [CHANNELS];
    bay_state_t        state_s  [CHANNELS];
    logic [TIME_W-1:0] remain_r [CHANNELS];
    logic [TIME_W-1:0] remain_s [CHANNELS];
    logic [RATE_W-1:0] rate_r   [CHANNELS];
    logic [RATE_W-1:0] rate_s   [CHANNELS];
    logic              accept_r, reject_r;
    logic              accept_s, reject_s;
    logic [RATE_W:0]   decode_s;
    logic              sel_ok_s;
    logic              target_idle_s;
    logic [CHANNELS-1:0] hit_s;

    // Request qualification: a Stop in the same cycle always forces a reject.
    always_comb begin
        decode_s      = decode_mode(mode);
        sel_ok_s      = (32'(chan_sel) < 32'(CHANNELS));
        target_idle_s = 1'b0;
        hit_s         = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            hit_s[i] = sel_ok_s && (32'(chan_sel) == 32'(i));
            if (hit_s[i] && (state_r[i] == ST_IDLE)) begin
                target_idle_s = 1'b1;
            end else begin
                target_idle_s = target_idle_s;
            end
        end
        accept_s = start && !stop && target_idle_s && decode_s[RATE_W]
                   && (duration != {TIME_W{1'b0}});
        reject_s = start && !accept_s;
    end

    // Per-bay session next state; Stop takes priority over Tick while charging.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_s[i]  = state_r[i];
            remain_s[i] = remain_r[i];
            rate_s[i]   = rate_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (accept_s && hit_s[i]) begin
                        state_s[i]  = ST_CHARGE;
                        remain_s[i] = duration;
                        rate_s[i]   = decode_s[RATE_W-1:0];
                    end else begin
                        state_s[i]  = ST_IDLE;
                    end
                end
                ST_CHARGE: begin
                    if (stop && hit_s[i]) begin
                        state_s[i]  = ST_IDLE;
                        remain_s[i] = {TIME_W{1'b0}};
                        rate_s[i]   = {RATE_W{1'b0}};
                    end else if (tick && (remain_r[i] == TIME_W'(1'b1))) begin
                        state_s[i]  = ST_DONE;
                        remain_s[i] = {TIME_W{1'b0}};
                        rate_s[i]   = {RATE_W{1'b0}};
                    end else if (tick && (remain_r[i] != {TIME_W{1'b0}})) begin
                        remain_s[i] = remain_r[i] - TIME_W'(1'b1);
                    end else begin
                        state_s[i]  = ST_CHARGE;
                    end
                end
                ST_DONE: begin
                    state_s[i]  = ST_IDLE;
                    remain_s[i] = {TIME_W{1'b0}};
                    rate_s[i]   = {RATE_W{1'b0}};
                end
                default: begin
                    state_s[i]  = ST_IDLE;
                    remain_s[i] = {TIME_W{1'b0}};
                    rate_s[i]   = {RATE_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous reset overriding all inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            accept_r <= 1'b0;
            reject_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i]  <= ST_IDLE;
                remain_r[i] <= {TIME_W{1'b0}};
                rate_r[i]   <= {RATE_W{1'b0}};
            end
        end else begin
            accept_r <= accept_s;
            reject_r <= reject_s;
            for (int i = 0; i < CHANNELS; i++) begin
                state_r[i]  <= state_s[i];
                remain_r[i] <= remain_s[i];
                rate_r[i]   <= rate_s[i];
            end
        end
    end

    assign accept = accept_r;
    assign reject = reject_r;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_bay
        assign busy[g]           = (state_r[g] != ST_IDLE);
        assign done[g]           = (state_r[g] == ST_DONE);
        assign counter_enable[g] = (state_r[g] == ST_CHARGE);
        assign counter_input[g*RATE_W +: RATE_W]  = rate_r[g];
        assign remaining_time[g*TIME_W +: TIME_W] = remain_r[g];
    end

endmodule

// File: doc/charge_session_ctrl.md
# charge_session_ctrl

Multi-bay charging session controller for the charging station. It accepts session requests (bay, mode, duration) and checks each against the mode table. For every bay it runs an independent session state machine that drives that bay's charge counter enable and rate, counts the session time down on a shared time-base tick, and reports completion. It replaces the single-bay, purely combinational mode-to-rate decode with registered, per-bay session tracking, explicit rejection of bad requests and abort support.

## Interface
Parameters:
- CHANNELS, 2: number of charging bays (≥1).
- TIME_W, 12: width of duration and remaining-time fields.
- MODE_W, 4: width of the mode code.
- RATE_W, 4: width of the per-bay counter rate output.

Ports (one clock; reset is synchronous and active-high):
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clears all state.
- Start  in  1  request strobe; sampled each cycle.
- Stop  in  1  abort strobe for the bay on ChanSel.
- ChanSel  in  max(1,$clog2(CHANNELS))  target bay for Start/Stop.
- Mode  in  MODE_W  requested charge mode.
- Duration  in  TIME_W  requested session length, in ticks.
- Tick  in  1  time-base strobe, one cycle wide.
- Accept  out  1  one-cycle pulse: last Start accepted.
- Reject  out  1  one-cycle pulse: last Start refused.
- Busy  out  CHANNELS  bay is in CHARGE or DONE.
- Done  out  CHANNELS  one-cycle pulse at normal session end.
- CounterEnable  out  CHANNELS  per-bay charge counter enable.
- CounterInput  out  CHANNELS*RATE_W  per-bay rate; bay i occupies bits [i*RATE_W +: RATE_W].
- RemainingTime  out  CHANNELS*TIME_W  per-bay ticks left, packed the same way as CounterInput.

## Operation
- Mode table:
  - 4'b0010 maps to rate 1 (normal).
  - 4'b1010 maps to rate 5 (fast).
  - Every other code is invalid. Invalid modes never produce X; they cause Reject.
- Per-bay states: IDLE, CHARGE, DONE.
- Start is accepted only when all of these hold: ChanSel < CHANNELS, the target bay is IDLE, Mode is valid, and Duration != 0. Otherwise Reject.
- On accept: the bay goes IDLE→CHARGE, RemainingTime loads Duration, and CounterInput loads the rate.
- In CHARGE:
  - CounterEnable=1 and CounterInput=rate.
  - Each Tick decrements RemainingTime by 1.
  - A Tick when RemainingTime==1 sets RemainingTime to 0 and moves the bay to DONE.
- DONE lasts exactly one cycle: Done[i]=1, CounterEnable=0, CounterInput=0, Busy=1. The bay then returns to IDLE.
- Stop on a bay in CHARGE moves it to IDLE next cycle, clears RemainingTime and CounterInput, and raises no Done. Stop on an IDLE or DONE bay has no effect.
- RemainingTime never wraps. Decrement occurs only in CHARGE, and only while the value is ≥1.
- Bays are independent. Tick applies to all bays in CHARGE simultaneously.

## Timing
- Reset value of all outputs is 0. All bays reset to IDLE. Reset overrides every other input in the same cycle, including mid-session.
- Start sampled at edge N: Accept or Reject is high during cycle N+1. In the same cycle N+1 the bay shows CHARGE, CounterEnable=1, and RemainingTime=Duration.
- Tick in the same cycle as an accepted Start: the freshly loaded Duration is not decremented.
- Start and Stop in the same cycle: Stop is applied to ChanSel's bay and Start is rejected.
- Tick and Stop in the same cycle on a charging bay: Stop wins.
- Duration=1: the first Tick after accept leads to DONE one cycle later.
- Accept and Reject are never high together. Both are 0 in any cycle not following a Start.

## Configuration
- CHARGE_BOOST_EN defined: mode 4'b1110 is valid with rate 9 (boost), and the rest of the behaviour is identical.
- CHARGE_BOOST_EN undefined: 4'b1110 is invalid and is rejected.

## Test plan
- Reset, then Start bay0, Mode 4'b0010, Duration 3 → Accept at N+1, CounterInput[0]=1, RemainingTime[0]=3. Three Ticks → RemainingTime counts 2,1,0, then Done[0] pulses for one cycle and the bay returns to IDLE.
- Start bay1, Mode 4'b1010, Duration 2 while bay0 is charging → Accept, CounterInput[1]=5. Both bays count down independently on shared Ticks.
- Start with Mode 4'b0000, with Duration 0, with ChanSel=CHANNELS, and to a busy bay → each gives Reject, and no state changes.
- Stop on bay0 mid-session with RemainingTime=5 → next cycle IDLE, RemainingTime 0, CounterEnable 0, no Done. Start and Stop together → Reject.
- Assert Reset while both bays are charging → next cycle all outputs 0 and all bays IDLE.
- Mode 4'b1110 → Accept with rate 9 when CHARGE_BOOST_EN is defined; Reject when it is undefined.
